// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, defaults and baud divider helper
//
// Purpose: common definitions for the UART receiver (and the future transmitter).
// Contents:
//   uart_state_e  - receiver FSM state encoding
//   DEFAULT_BAUD  - default line bit rate
//   DEFAULT_OVS   - default oversampling ticks per bit
//   calc_div()    - clocks per oversampling tick, truncating division
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_e;

  localparam int DEFAULT_CLK_HZ = 100_000_000;
  localparam int DEFAULT_BAUD   = 9600;
  localparam int DEFAULT_OVS    = 16;

  // A divider below 1 would mean no ticks at all; clamp so the counter still runs.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    int div;
    div = clk_hz / (baud * ovs);
    if (div < 1) div = 1;
    return div;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running oversampling tick generator
//
// Purpose: divides the system clock down to BAUD*OVS ticks per second.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   tick  - one-clock pulse each time the divider counter wraps
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int BAUD   = DEFAULT_BAUD,
  parameter int OVS    = DEFAULT_OVS
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVS);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver
//
// Purpose: synchronizes rx, assembles 8N1 frames and strobes each good byte.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   rx         - serial line, idle high, asynchronous to clk
//   rx_data    - last correctly framed byte, held between frames
//   rx_done    - one-clock strobe, rx_data valid in the same cycle
//   frame_err  - one-clock strobe when the stop bit is sampled low
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int BAUD   = DEFAULT_BAUD,
  parameter int OVS    = DEFAULT_OVS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] TC_HALF = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TC_LAST = TW'(OVS - 1);

  logic tick;

  baud_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .OVS    (OVS)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer, reset high so reset never looks like a start bit.
  logic rx_meta_q;
  logic rx_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  uart_state_e   state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_done_q, rx_done_d;
  logic          frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    bcnt_d      = bcnt_q;
    sh_d        = sh_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_sync_q) begin
            state_d = ST_START;
            tcnt_d  = '0;
          end
        end

        // Re-check the line at mid start bit to reject short glitches.
        ST_START: begin
          if (tcnt_q == TC_HALF) begin
            tcnt_d = '0;
            if (!rx_sync_q) begin
              state_d = ST_DATA;
              bcnt_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end

        // Aligned at mid start bit, so every OVS ticks lands on a bit centre.
        ST_DATA: begin
          if (tcnt_q == TC_LAST) begin
            tcnt_d = '0;
            sh_d   = {rx_sync_q, sh_q[7:1]};
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_d = ST_STOP;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end

        // Deciding at mid stop bit frees the receiver for a back-to-back start.
        ST_STOP: begin
          if (tcnt_q == TC_LAST) begin
            tcnt_d = '0;
            if (rx_sync_q) begin
              rx_data_d = sh_q;
              rx_done_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_WAIT_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end

        // A stuck-low line must go high before another frame can start.
        ST_WAIT_IDLE: begin
          if (rx_sync_q) begin
            state_d = ST_IDLE;
            tcnt_d  = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          tcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      sh_q        <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
      sh_q        <= sh_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;

endmodule
